// File: rtl/wb_pkg.sv
// Shared constants for the M->W writeback stage: result-source indices and
// load funct3 encodings.
package wb_pkg;

  localparam int SRC_ALU  = 0;
  localparam int SRC_LOAD = 1;
  localparam int SRC_PC4  = 2;
  localparam int SRC_CSR  = 3;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct3_e;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Sub-word load extraction and sign/zero extension. Misaligned offsets are
// truncated to the access size; codes that do not exist for XLEN pass data through.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  data,
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] offset,
  output logic [XLEN-1:0]  ext
);

  localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1);
  localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(3);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    byte_v = 8'(data >> {offset, 3'b000});
    half_v = 16'(data >> {offset & HALF_MASK, 3'b000});
    word_v = 32'(data >> {offset & WORD_MASK, 3'b000});
    ext    = data;
    case (load_funct3_e'(funct3))
      LB:      ext = XLEN'($signed(byte_v));
      LBU:     ext = XLEN'(byte_v);
      LH:      ext = XLEN'($signed(half_v));
      LHU:     ext = XLEN'(half_v);
      // With XLEN=32 the word mask clears the offset, so this is the raw word.
      LW:      ext = XLEN'($signed(word_v));
      LWU:     ext = (XLEN == 64) ? XLEN'(word_v) : data;
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// M->W pipeline register with result select, load extension, write-enable
// qualification and a 64-bit retired-instruction counter.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 4,
  parameter int REG_ADDR_W = 5,
  parameter int SRC_W      = $clog2(NUM_SRC)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             valid_m_i,
  input  logic [NUM_SRC-1:0][XLEN-1:0]     src_data_m_i,
  input  logic [REG_ADDR_W-1:0]            rd_m_i,
  input  logic                             reg_write_m_i,
  input  logic [SRC_W-1:0]                 result_src_m_i,
  input  logic [2:0]                       load_funct3_m_i,
  input  logic                             stall_w_i,
  input  logic                             flush_w_i,
  output logic [XLEN-1:0]                  result_w_o,
  output logic [REG_ADDR_W-1:0]            rd_w_o,
  output logic                             reg_write_w_o,
  output logic                             valid_w_o,
  output logic [63:0]                      retired_count_o
);

  localparam int OFF_W = $clog2(XLEN / 8);

  logic                         valid_w;
  logic                         reg_write_w;
  logic [REG_ADDR_W-1:0]        rd_w;
  logic [NUM_SRC-1:0][XLEN-1:0] src_data_w;
  logic [SRC_W-1:0]             result_src_w;
  logic [2:0]                   funct3_w;
  logic [OFF_W-1:0]             off_w;
  logic [63:0]                  retired_cnt;
  logic [XLEN-1:0]              load_ext;
  logic [XLEN-1:0]              result;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      rd_w         <= '0;
      src_data_w   <= '0;
      result_src_w <= '0;
      funct3_w     <= '0;
      off_w        <= '0;
    end else if (flush_w_i) begin
      // Squash only the control bits; stale data is harmless once invalid.
      valid_w     <= 1'b0;
      reg_write_w <= 1'b0;
    end else if (!stall_w_i) begin
      valid_w      <= valid_m_i;
      reg_write_w  <= reg_write_m_i;
      rd_w         <= rd_m_i;
      src_data_w   <= src_data_m_i;
      result_src_w <= result_src_m_i;
      funct3_w     <= load_funct3_m_i;
      off_w        <= src_data_m_i[SRC_ALU][OFF_W-1:0];
    end
  end

  // The instruction sitting in W retires on any non-stalled edge, flushed or not.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      retired_cnt <= '0;
    end else if (valid_w && !stall_w_i) begin
      retired_cnt <= retired_cnt + 64'd1;
    end
  end

  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .data   (src_data_w[SRC_LOAD]),
    .funct3 (funct3_w),
    .offset (off_w),
    .ext    (load_ext)
  );

  // Out-of-range selects fall through to zero.
  always_comb begin
    result = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (result_src_w == SRC_W'(i)) begin
        result = (i == SRC_LOAD) ? load_ext : src_data_w[i];
      end
    end
  end

  assign result_w_o      = result;
  assign rd_w_o          = rd_w;
  assign valid_w_o       = valid_w;
  assign reg_write_w_o   = valid_w & reg_write_w & (rd_w != '0);
  assign retired_count_o = retired_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (XLEN=32, NUM_SRC=4 and NUM_SRC=3).
module tb_writeback_stage;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  logic             valid_m, reg_write_m, stall, flush;
  logic [3:0][31:0] src_data_m;
  logic [4:0]       rd_m;
  logic [1:0]       result_src_m;
  logic [2:0]       funct3_m;
  logic [31:0]      result_w;
  logic [4:0]       rd_w;
  logic             reg_write_w, valid_w;
  logic [63:0]      retired;

  logic             valid3, reg_write3;
  logic [2:0][31:0] src_data3;
  logic [4:0]       rd3;
  logic [1:0]       result_src3;
  logic [31:0]      result3;
  logic [4:0]       rd_w3;
  logic             reg_write_w3, valid_w3;
  logic [63:0]      retired3;

  int checks = 0;
  int failures = 0;

  writeback_stage #(.XLEN(32), .NUM_SRC(4), .REG_ADDR_W(5)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .valid_m_i       (valid_m),
    .src_data_m_i    (src_data_m),
    .rd_m_i          (rd_m),
    .reg_write_m_i   (reg_write_m),
    .result_src_m_i  (result_src_m),
    .load_funct3_m_i (funct3_m),
    .stall_w_i       (stall),
    .flush_w_i       (flush),
    .result_w_o      (result_w),
    .rd_w_o          (rd_w),
    .reg_write_w_o   (reg_write_w),
    .valid_w_o       (valid_w),
    .retired_count_o (retired)
  );

  writeback_stage #(.XLEN(32), .NUM_SRC(3), .REG_ADDR_W(5)) dut3 (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .valid_m_i       (valid3),
    .src_data_m_i    (src_data3),
    .rd_m_i          (rd3),
    .reg_write_m_i   (reg_write3),
    .result_src_m_i  (result_src3),
    .load_funct3_m_i (3'b010),
    .stall_w_i       (stall),
    .flush_w_i       (flush),
    .result_w_o      (result3),
    .rd_w_o          (rd_w3),
    .reg_write_w_o   (reg_write_w3),
    .valid_w_o       (valid_w3),
    .retired_count_o (retired3)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                           input logic [31:0] expected);
    valid_m       = 1'b1;
    reg_write_m   = 1'b1;
    rd_m          = 5'd7;
    result_src_m  = 2'(SRC_LOAD);
    funct3_m      = f3;
    src_data_m[0] = alu;
    src_data_m[1] = 32'h80FF_7F01;
    tick();
    check(tag, 64'(result_w), 64'(expected));
  endtask

  initial begin
    valid_m = 0; reg_write_m = 0; stall = 0; flush = 0;
    src_data_m = '0; rd_m = '0; result_src_m = '0; funct3_m = '0;
    valid3 = 0; reg_write3 = 0; src_data3 = '0; rd3 = '0; result_src3 = '0;

    #1 reset_i = 1'b1;
    #2;
    check("reset_valid", 64'(valid_w), 64'd0);
    check("reset_rw", 64'(reg_write_w), 64'd0);
    check("reset_result", 64'(result_w), 64'd0);
    check("reset_rd", 64'(rd_w), 64'd0);
    check("reset_cnt", retired, 64'd0);
    repeat (2) tick();
    reset_i = 1'b0;

    // ALU writeback
    valid_m = 1; reg_write_m = 1; rd_m = 5'd5; result_src_m = 2'(SRC_ALU);
    funct3_m = 3'b010; src_data_m[0] = 32'h0000_1234;
    src_data_m[2] = 32'h0000_1004; src_data_m[3] = 32'hC5C5_0000;
    tick();
    check("alu_result", 64'(result_w), 64'h1234);
    check("alu_rd", 64'(rd_w), 64'd5);
    check("alu_rw", 64'(reg_write_w), 64'd1);
    check("alu_valid", 64'(valid_w), 64'd1);
    check("alu_cnt_lag", retired, 64'd0);
    valid_m = 0;
    tick();
    check("cnt_first", retired, 64'd1);
    check("bubble_rw", 64'(reg_write_w), 64'd0);

    // Sub-word loads from 0x80FF_7F01
    load_case("lb_off2",  3'b000, 32'h1000_0002, 32'hFFFF_FFFF);
    load_case("lbu_off2", 3'b100, 32'h1000_0002, 32'h0000_00FF);
    load_case("lh_off2",  3'b001, 32'h1000_0002, 32'hFFFF_80FF);
    load_case("lhu_off2", 3'b101, 32'h1000_0002, 32'h0000_80FF);
    load_case("lb_off1",  3'b000, 32'h1000_0001, 32'h0000_007F);
    check("cnt_after_loads", retired, 64'd5);

    // Write to x0 suppressed; out-of-range select on NUM_SRC=3 gives zero
    valid_m = 1; reg_write_m = 1; rd_m = 5'd0; result_src_m = 2'(SRC_ALU);
    src_data_m[0] = 32'h0000_0055;
    valid3 = 1; reg_write3 = 1; rd3 = 5'd4; result_src3 = 2'd3;
    src_data3[0] = 32'h1111_1111; src_data3[1] = 32'h2222_2222; src_data3[2] = 32'h3333_3333;
    tick();
    check("x0_rw", 64'(reg_write_w), 64'd0);
    check("x0_valid", 64'(valid_w), 64'd1);
    check("src3_oob", 64'(result3), 64'd0);
    check("cnt_x0", retired, 64'd6);

    valid_m = 1; reg_write_m = 1; rd_m = 5'd9; src_data_m[0] = 32'hAAAA_0001;
    result_src3 = 2'(SRC_PC4);
    tick();
    check("held_result", 64'(result_w), 64'hAAAA_0001);
    check("held_rd", 64'(rd_w), 64'd9);
    check("src3_pc4", 64'(result3), 64'h3333_3333);
    check("cnt_pre_stall", retired, 64'd7);

    // Stall 3 cycles while M inputs change
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      valid_m = i[0]; rd_m = 5'(12 + i); src_data_m[0] = 32'hDEAD_0000 + 32'(i);
      tick();
    end
    check("stall_result", 64'(result_w), 64'hAAAA_0001);
    check("stall_rd", 64'(rd_w), 64'd9);
    check("stall_valid", 64'(valid_w), 64'd1);
    check("stall_cnt", retired, 64'd7);

    // Stall and flush together: flush wins, no retire since stalled
    flush = 1;
    tick();
    check("sf_valid", 64'(valid_w), 64'd0);
    check("sf_rw", 64'(reg_write_w), 64'd0);
    check("sf_cnt", retired, 64'd7);

    // Flush alone still retires the instruction already in W
    stall = 0; flush = 0; valid_m = 1; rd_m = 5'd3; src_data_m[0] = 32'h77;
    tick();
    flush = 1;
    tick();
    check("flush_valid", 64'(valid_w), 64'd0);
    check("flush_cnt", retired, 64'd8);

    // Asynchronous reset between edges while stalled
    flush = 0;
    tick();
    stall = 1;
    #2 reset_i = 1'b1;
    #1;
    check("areset_valid", 64'(valid_w), 64'd0);
    check("areset_result", 64'(result_w), 64'd0);
    check("areset_rd", 64'(rd_w), 64'd0);
    check("areset_cnt", retired, 64'd0);
    tick();
    reset_i = 1'b0; stall = 0; valid_m = 0;

    // Counter wrap
    force dut.retired_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.retired_cnt;
    tick();
    check("wrap_pre", retired, 64'hFFFF_FFFF_FFFF_FFFF);
    valid_m = 1; rd_m = 5'd1;
    tick();
    valid_m = 0;
    tick();
    check("wrap_zero", retired, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Parametrised M->W pipeline register and result-select stage for the RISC-V core datapath.
- Captures memory-stage results and selects one of NUM_SRC sources for register-file writeback.
- Sign- or zero-extends sub-word loads using funct3 and the address byte offset.
- Supports stall and flush, and gates the register write enable.
- Maintains a 64-bit retired-instruction counter.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
NUM_SRC, 4, number of result sources; minimum 3
REG_ADDR_W, 5, register index width
SRC_W, $clog2(NUM_SRC), width of result_src

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
valid_m_i  in  1  M-stage instruction valid
src_data_m_i  in  NUM_SRC x XLEN  packed source array; index per wb_pkg (0 ALU, 1 load data, 2 PC+4, 3 CSR)
rd_m_i  in  REG_ADDR_W  destination register
reg_write_m_i  in  1  instruction writes rd
result_src_m_i  in  SRC_W  result select
load_funct3_m_i  in  3  load funct3
stall_w_i  in  1  hold W register
flush_w_i  in  1  squash M->W transfer
result_w_o  out  XLEN  writeback data
rd_w_o  out  REG_ADDR_W  writeback register
reg_write_w_o  out  1  qualified register write enable
valid_w_o  out  1  W-stage valid
retired_count_o  out  64  retired-instruction count

Behaviour:
- Clocking and reset: clock port clk_i, reset port reset_i; reset is asynchronous and active-high.
- Reset values: all W registers 0, so valid_w_o=0, reg_write_w_o=0, result_w_o=0, rd_w_o=0, retired_count_o=0. Reset asserted mid-stall or mid-flush takes priority immediately.
- W-register update, evaluated each posedge in priority order:
  - flush_w_i=1: valid_w<=0 and reg_write_w<=0; data fields may load or hold.
  - else stall_w_i=1: all W registers hold.
  - else: capture valid_m_i, src_data_m_i, rd_m_i, reg_write_m_i, result_src_m_i, load_funct3_m_i, and the byte offset alu[$clog2(XLEN/8)-1:0].
- Flush beats stall when both are asserted.
- Latency: 1 cycle from M inputs to W outputs; all outputs are combinational from W registers.
- Result mux:
  - result_src index < NUM_SRC selects that source.
  - Index 1 (load) passes through the load extender.
  - Index >= NUM_SRC yields 0.
- Load extender, with byte offset off:
  - LB/LBU (000/100): byte at off*8, sign/zero-extended.
  - LH/LHU (001/101): halfword at (off & ~1)*8, sign/zero-extended.
  - LW (010): for XLEN=32, the raw word; for XLEN=64, word at (off & ~3)*8, sign-extended.
  - LWU (110): XLEN=64 only, zero-extended.
  - LD (011): XLEN=64 only, the raw doubleword.
  - Any other funct3, or a 64-bit-only code with XLEN=32: raw data unchanged.
  - Misaligned offsets are truncated as above; no trap is raised here.
- reg_write_w_o = valid_w & reg_write_w & (rd_w != 0). A write to x0 is never asserted.
- Retired counter: increments by 1 on each posedge where valid_w=1 and stall_w_i=0. It wraps modulo 2^64 with no flag. Flush does not affect the instruction already in W.

Decomposition:
- Package wb_pkg holds:
  - Source index constants SRC_ALU=0, SRC_LOAD=1, SRC_PC4=2, SRC_CSR=3.
  - Load funct3 constants LB, LH, LW, LD, LBU, LHU, LWU.
- One combinational sub-module, load_extend, parametrised by XLEN, with inputs (data, funct3, offset) and output (extended data).
- The pipeline register, result mux, write-enable qualification and counter live in writeback_stage.

Test Plan:
- Reset asserted mid-stream, asynchronously between edges -> all outputs 0 immediately, with no clock edge required.
- valid=1, src=0, ALU=0x0000_1234, rd=5, reg_write=1 -> next cycle result_w_o=0x0000_1234, rd_w_o=5, reg_write_w_o=1; counter becomes 1 one cycle later.
- Load word 0x80FF_7F01, ALU low bits=2:
  - LB -> 0xFFFF_FFFF.
  - LBU -> 0x0000_00FF.
  - LH -> 0xFFFF_80FF.
  - LHU -> 0x0000_80FF.
  - LB with offset 1 -> 0x0000_007F.
- rd=0 with reg_write=1 -> reg_write_w_o=0. Separately, result_src=3 with NUM_SRC=3 -> result_w_o=0.
- stall held 3 cycles while M inputs change -> W outputs frozen and counter unchanged. Then stall and flush asserted together -> valid_w_o=0 on the next edge, and the counter increments by 1 for the held instruction only if stall was 0 on that edge.
- Preload the counter near its top via a sequence; in a short-sim variant, force the counter to 0xFFFF_FFFF_FFFF_FFFF -> one retire gives 0 (wrap).
